// File: rtl/t_counter_mod.sv
// Modulo-N up/down counter built from a bank of toggle flops.
// Supports programmable modulus, load, clear, terminal-count and wrap flags.
module t_counter_mod #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sclr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qbar_q;
    logic             wrap_q, wrap_d;
    logic             lerr_q, lerr_d;
    logic [WIDTH-1:0] tog_up, tog_dn;
    logic             load_oor;
    logic             at_top, at_bot;

    assign load_oor = 64'(load_val) >= MODULUS;
    // Anything at or above the top value wraps when counting up.
    assign at_top   = q_q >= MAX_V;
    assign at_bot   = q_q == '0;

    // T-flop toggle vectors: a bit flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic all1;
        logic all0;
        all1   = 1'b1;
        all0   = 1'b1;
        tog_up = '0;
        tog_dn = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            tog_up[i] = all1;
            tog_dn[i] = all0;
            all1      = all1 & q_q[i];
            all0      = all0 & ~q_q[i];
        end
    end

    // Next state: clear beats load beats count; wrap and load override the toggles.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        lerr_d = 1'b0;
        if (sclr) begin
            q_d = '0;
        end else if (load) begin
            if (load_oor) begin
                q_d    = MAX_V;
                lerr_d = 1'b1;
            end else begin
                q_d = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                if (at_top) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q ^ tog_up;
                end
            end else begin
                if (at_bot) begin
                    q_d    = MAX_V;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q ^ tog_dn;
                end
            end
        end
    end

    // State bank; qbar is loaded from the same next value so it can never diverge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= RST_V;
            qbar_q <= ~RST_V;
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            qbar_q <= ~q_d;
            wrap_q <= wrap_d;
            lerr_q <= lerr_d;
        end
    end

    assign q        = q_q;
    assign qbar     = qbar_q;
    assign wrap     = wrap_q;
    assign load_err = lerr_q;
    assign tc       = en & ~sclr & ~load & (up_dn ? (q_q == MAX_V) : at_bot);

endmodule
